seq_restoring_divider: RTL and testbench

- Iterative unsigned restoring divider: the inverse operation to the team's multiplier datapath (dividend / divisor -> quotient, remainder).
- One quotient bit per clock, with a start/busy/done handshake.
- The trial subtraction is built from the same NAND-universal gate style as the multiplier cells.
- Sits beside the multiplier as its companion arithmetic unit.

---
 rtl/div_pkg.sv | 15 +
 rtl/seq_restoring_divider_nand_sub_cell.sv | 31 +++
 rtl/seq_restoring_divider.sv | 133 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Iteration counter must be able to hold the value WIDTH.
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_restoring_divider_nand_sub_cell.sv
// One-bit full subtractor (diff = a - b - borrow_in) built only from 2-input NANDs.
module nand_sub_cell (
   input  logic a,
   input  logic b,
   input  logic borrow_in,
   output logic diff,
   output logic borrow_out
);

   logic t1, t2, t3, b_xor_bin;
   logic u1, u2, u3;
   logic not_a, v1;

   // b ^ borrow_in
   assign t1        = ~(b & borrow_in);
   assign t2        = ~(b & t1);
   assign t3        = ~(borrow_in & t1);
   assign b_xor_bin = ~(t2 & t3);

   // a ^ (b ^ borrow_in)
   assign u1   = ~(a & b_xor_bin);
   assign u2   = ~(a & u1);
   assign u3   = ~(b_xor_bin & u1);
   assign diff = ~(u2 & u3);

   // borrow_out = (~a & (b ^ borrow_in)) | (b & borrow_in)
   assign not_a      = ~(a & a);
   assign v1         = ~(not_a & b_xor_bin);
   assign borrow_out = ~(v1 & t1);

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes directly from IDLE.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = cnt_width(WIDTH);

   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] rem_reg;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] divisor_reg;
   logic             busy_reg;
   logic             done_reg;
   logic [WIDTH-1:0] quotient_reg;
   logic [WIDTH-1:0] remainder_reg;
   logic             div_by_zero_reg;

   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   divisor_ext;
   logic [WIDTH:0]   trial;
   logic [WIDTH+1:0] borrow;
   logic             trial_neg;
   logic             trial_msb_unused;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] q_next;

   assign rem_shift   = {rem_reg, q_reg[WIDTH-1]};
   assign divisor_ext = {1'b0, divisor_reg};
   assign borrow[0]   = 1'b0;

   generate
      for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_sub
         nand_sub_cell u_cell (
            .a          (rem_shift[gi]),
            .b          (divisor_ext[gi]),
            .borrow_in  (borrow[gi]),
            .diff       (trial[gi]),
            .borrow_out (borrow[gi+1])
         );
      end
   endgenerate

   // A borrow out of the top cell means the trial went negative: restore.
   assign trial_neg        = borrow[WIDTH+1];
   assign trial_msb_unused = trial[WIDTH];

   always_comb begin
      rem_next = trial_neg ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
      q_next   = {q_reg[WIDTH-2:0], ~trial_neg};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         rem_reg         <= '0;
         q_reg           <= '0;
         divisor_reg     <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         quotient_reg    <= '0;
         remainder_reg   <= '0;
         div_by_zero_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  divisor_reg <= divisor;
                  rem_reg     <= '0;
                  q_reg       <= dividend;
                  cnt_reg     <= CW'(WIDTH);
                  busy_reg    <= 1'b1;
`ifdef DIV_ZERO_FAST_EN
                  if (divisor == '0) begin
                     state_reg       <= DONE;
                     done_reg        <= 1'b1;
                     quotient_reg    <= '1;
                     remainder_reg   <= dividend;
                     div_by_zero_reg <= 1'b1;
                  end else begin
                     state_reg <= RUN;
                  end
`else
                  state_reg <= RUN;
`endif
               end
            end
            RUN: begin
               rem_reg <= rem_next;
               q_reg   <= q_next;
               cnt_reg <= cnt_reg - CW'(1);
               // Results are registered on the last iteration so they are valid with done.
               if (cnt_reg == CW'(1)) begin
                  state_reg       <= DONE;
                  done_reg        <= 1'b1;
                  quotient_reg    <= q_next;
                  remainder_reg   <= rem_next;
                  div_by_zero_reg <= (divisor_reg == '0);
               end
            end
            DONE: begin
               busy_reg  <= 1'b0;
               cnt_reg   <= '0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign busy        = busy_reg;
   assign done        = done_reg;
   assign quotient    = quotient_reg;
   assign remainder   = remainder_reg;
   assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (WIDTH=8); honours DIV_ZERO_FAST_EN.
module tb_seq_restoring_divider;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
      int           lat;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   exp_t         sb[$];
   int           tests;
   int           failed;
   logic [W-1:0] last_q;
   logic [W-1:0] last_r;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      if (obs !== exp) begin
         failed++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      if (b == 0) begin
         e.q  = '1;
         e.r  = a;
         e.dz = 1'b1;
`ifdef DIV_ZERO_FAST_EN
         e.lat = 1;
`else
         e.lat = W + 1;
`endif
      end else begin
         e.q   = a / b;
         e.r   = a % b;
         e.dz  = 1'b0;
         e.lat = W + 1;
      end
      return e;
   endfunction

   // Drives one operation in the current cycle; optionally pulses start with
   // other operands in cycle inj (which must be ignored).
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj, input logic [W-1:0] ia, input logic [W-1:0] ib);
      exp_t e;
      int   cyc;
      bit   got;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      sb.push_back(model(a, b));
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 1;
      got   = 0;
      while (cyc <= 20 && !got) begin
         if (cyc == inj) begin
            start    = 1'b1;
            dividend = ia;
            divisor  = ib;
         end else begin
            start = 1'b0;
         end
         check("busy", busy, 1);
         if (done) begin
            got = 1;
            e   = sb.pop_front();
            check("latency", cyc, e.lat);
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_by_zero", div_by_zero, e.dz);
            if (b != 0) begin
               check("identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
               check("rem_lt_div", 32'(remainder < b), 1);
            end
            $display("[TB] op %0d/%0d -> q=%0d r=%0d dz=%0d after %0d cycles",
                     a, b, quotient, remainder, div_by_zero, cyc);
            last_q = e.q;
            last_r = e.r;
         end else begin
            check("hold_q", quotient, last_q);
            check("hold_r", remainder, last_r);
            @(posedge clk); #1;
            cyc++;
         end
      end
      start = 1'b0;
      if (!got) begin
         check("done_timeout", 0, 1);
         void'(sb.pop_front());
      end
      @(posedge clk); #1;
      check("done_pulse_end", done, 0);
      check("busy_end", busy, 0);
   endtask

   initial begin
      tests    = 0;
      failed   = 0;
      last_q   = '0;
      last_r   = '0;
      rst_n    = 1'b0;
      start    = 1'b0;
      dividend = '0;
      divisor  = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_q", quotient, 0);
      check("rst_r", remainder, 0);
      check("rst_dz", div_by_zero, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(8'd100, 8'd7, 0, 8'd0, 8'd0);
      run_op(8'd255, 8'd1, 0, 8'd0, 8'd0);
      run_op(8'd5, 8'd9, 0, 8'd0, 8'd0);
      run_op(8'd200, 8'd0, 0, 8'd0, 8'd0);
      run_op(8'd100, 8'd7, 4, 8'd50, 8'd5);
      run_op(8'd50, 8'd5, 0, 8'd0, 8'd0);

      // Asynchronous reset in the middle of 100/7.
      start    = 1'b1;
      dividend = 8'd100;
      divisor  = 8'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_q", quotient, 0);
      check("abort_r", remainder, 0);
      check("abort_dz", div_by_zero, 0);
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         check("abort_no_done", done, 0);
         if (i == 2) rst_n = 1'b1;
      end
      $display("[TB] op 100/7 aborted by reset");
      last_q = '0;
      last_r = '0;
      run_op(8'd9, 8'd3, 0, 8'd0, 8'd0);

      for (int n = 0; n < 1000; n++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = W'($urandom_range(0, 255));
         rb = (n % 50 == 0) ? 8'd0 : W'($urandom_range(1, 255));
         run_op(ra, rb, 0, 8'd0, 8'd0);
      end

      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
